// File: rtl/dc_pwm_pkg.sv
// Shared types and defaults for the dc_pwm gate-drive stage.
package dc_pwm_pkg;

    // Run/idle state of the PWM sequencer.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_t;

    // Default duty/period/counter width, matching the control datapath duty register.
    localparam int DUTY_W_DEF = 14;

    // Default dead-time counter width.
    localparam int DT_W_DEF = 6;

    // Smallest terminal count the counter ever runs with; shorter periods are stretched.
    localparam int PER_MIN = 2;

endpackage : dc_pwm_pkg

// File: rtl/dc_deadtime.sv
// One dead-time leg: delays the rising edge of its input by a programmable
// number of clocks, passes falling edges through after one clock, and swallows
// pulses that are too short to outlast the delay. The gate output is registered.
module dc_deadtime
    import dc_pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in,
    input  logic [DT_W-1:0] dt,
    input  logic            kill,
    output logic            out
);

    logic            r_in_d;
    logic [DT_W-1:0] r_cnt;
    logic            r_out;
    logic            w_rise;

    // A rise is the input high now while it was low (or killed) the cycle before.
    assign w_rise = in & ~r_in_d;

    // Edge tracking, turn-on delay countdown and gate register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_d <= 1'b0;
            r_cnt  <= '0;
            r_out  <= 1'b0;
        end else if (kill) begin
            // Forget the input history so the next high level counts as a fresh rise.
            r_in_d <= 1'b0;
            r_cnt  <= '0;
            r_out  <= 1'b0;
        end else begin
            r_in_d <= in;
            if (!in) begin
                // Falling edge (or still low): drop the gate and cancel any pending rise.
                r_cnt <= '0;
                r_out <= 1'b0;
            end else if (w_rise) begin
                // Dead time is sampled here, once per rising edge.
                if (dt == '0) begin
                    r_cnt <= '0;
                    r_out <= 1'b1;
                end else begin
                    r_cnt <= dt;
                    r_out <= 1'b0;
                end
            end else if (r_cnt > DT_W'(1)) begin
                r_cnt <= r_cnt - DT_W'(1);
            end else begin
                // Delay expired with the input still high: turn the gate on (or keep it on).
                r_cnt <= '0;
                r_out <= 1'b1;
            end
        end
    end

    assign out = r_out;

endmodule : dc_deadtime

// File: rtl/dc_pwm.sv
// Complementary PWM stage: shadowed duty/period, period counter with a
// per-period start strobe, clamped compare, and two dead-time protected legs.
module dc_pwm
    import dc_pwm_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF,
    parameter int DT_W   = DT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DUTY_W-1:0] duty,
    input  logic              duty_vld,
    input  logic [DUTY_W-1:0] period,
    input  logic [DT_W-1:0]   deadtime,
    output logic              pwm_hi,
    output logic              pwm_lo,
    output logic              cyc_start,
    output logic [DUTY_W-1:0] duty_act
);

    pwm_state_t        r_state;
    pwm_state_t        w_state_nxt;
    logic              w_load;

    logic [DUTY_W-1:0] r_cnt;
    logic [DUTY_W-1:0] r_per_act;
    logic [DUTY_W-1:0] r_duty_act;
    logic [DUTY_W-1:0] r_duty_sh;
    logic              r_cyc_start;

    logic [DUTY_W-1:0] w_per_new;
    logic [DUTY_W-1:0] w_duty_src;
    logic [DUTY_W:0]   w_lim;
    logic [DUTY_W-1:0] w_duty_clamped;
    logic              w_raw;
    logic              w_kill;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and the shadow-load strobe (period boundary or start of run).
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == r_per_act) begin
                    w_load = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Period to be loaded at the next boundary, stretched to the minimum length.
    assign w_per_new = (period < DUTY_W'(PER_MIN)) ? DUTY_W'(PER_MIN) : period;

    // A strobe landing on the load cycle bypasses the shadow register.
    assign w_duty_src = duty_vld ? duty : r_duty_sh;

    // Largest useful compare value: one past the terminal count gives 100 % duty.
    assign w_lim = {1'b0, w_per_new} + (DUTY_W + 1)'(1);

    // Clamp the signed duty word into [0, per_act+1] against the period being loaded.
    always_comb begin
        w_duty_clamped = w_duty_src;
        if (w_duty_src[DUTY_W-1]) begin
            w_duty_clamped = '0;
        end else if ({1'b0, w_duty_src} > w_lim) begin
            w_duty_clamped = w_lim[DUTY_W-1:0];
        end
    end

    // Period counter: restarts at each load, held at zero while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_load || (w_state_nxt == IDLE)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DUTY_W'(1);
        end
    end

    // Shadow register: the last duty strobe wins, whether running or idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty_sh <= '0;
        end else if (duty_vld) begin
            r_duty_sh <= duty;
        end
    end

    // Active period/compare values change only on a load, keeping each period glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per_act  <= DUTY_W'(PER_MIN);
            r_duty_act <= '0;
        end else if (w_load) begin
            r_per_act  <= w_per_new;
            r_duty_act <= w_duty_clamped;
        end
    end

    // Start strobe lands on the same cycle the counter reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc_start <= 1'b0;
        end else begin
            r_cyc_start <= w_load;
        end
    end

    // Raw compare; the legs are held off whenever the stage is not running with en high.
    assign w_raw  = (r_cnt < r_duty_act);
    assign w_kill = !((r_state == RUN) && en);

    dc_deadtime #(
        .DT_W (DT_W)
    ) u_dt_hi (
        .clk  (clk),
        .rst  (rst),
        .in   (w_raw),
        .dt   (deadtime),
        .kill (w_kill),
        .out  (pwm_hi)
    );

    dc_deadtime #(
        .DT_W (DT_W)
    ) u_dt_lo (
        .clk  (clk),
        .rst  (rst),
        .in   (~w_raw),
        .dt   (deadtime),
        .kill (w_kill),
        .out  (pwm_lo)
    );

    assign cyc_start = r_cyc_start;
    assign duty_act  = r_duty_act;

endmodule : dc_pwm

// File: doc/dc_pwm.md
# dc_pwm

Digital-control PWM stage directly downstream of the control datapath. It consumes the 14-bit signed duty word the datapath writes into its duty register and turns it into a complementary, dead-time-protected gate-drive pair. It also issues the per-period start strobe that kicks off the next measurement and control computation. Duty updates are shadowed so that every PWM period runs with one glitch-free compare value.

## Interface
Parameters:
- `DUTY_W`, default 14: duty, period and counter width.
- `DT_W`, default 6: dead-time counter width.

Ports:
- `clk`, in, 1: sole clock.
- `rst`, in, 1: reset. Asynchronous and active-high.
- `en`, in, 1: run enable, level.
- `duty`, in, DUTY_W: signed two's-complement duty from the datapath duty register.
- `duty_vld`, in, 1: one-cycle strobe. Captures `duty` into the shadow register. Driven alongside the datapath duty-register enable.
- `period`, in, DUTY_W: unsigned terminal count. PWM period is `period`+1 clocks. Values below 2 are treated as 2.
- `deadtime`, in, DT_W: dead time in clocks. 0 disables dead time.
- `pwm_hi`, out, 1: high-side gate. Registered.
- `pwm_lo`, out, 1: low-side gate. Registered.
- `cyc_start`, out, 1: one-cycle pulse on the first cycle (cnt=0) of every period.
- `duty_act`, out, DUTY_W: clamped compare value currently in use.

## Operation
- **FSM** `{IDLE, RUN}`.
  - IDLE: cnt=0, both gates 0, `cyc_start`=0.
  - `en`=1 in IDLE → RUN next cycle. The first RUN cycle has cnt=0 and asserts `cyc_start`.
  - `en`=0 in any RUN cycle → IDLE next cycle. Both gates go low on that edge, regardless of dead-time state.
- **Counter**:
  - In RUN, cnt increments by 1 each cycle.
  - When cnt == `per_act`, cnt wraps to 0 on the next cycle.
- **Shadowing**:
  - On `duty_vld`, `duty` is written to `duty_sh`. The last write wins.
  - At each wrap and at IDLE→RUN, `per_act` ← max(`period`, 2) and `duty_act` ← clamp(`duty_sh`). This load uses the new `per_act`.
  - If `duty_vld` coincides with the load cycle, the incoming `duty` is the value loaded, bypassing `duty_sh`.
- **Clamp**:
  - `duty` < 0 → 0.
  - `duty` > `per_act`+1 → `per_act`+1.
  - Otherwise unchanged.
- **Raw compare**: `raw` = (cnt < `duty_act`).
  - 0 gives 0 % duty.
  - `per_act`+1 gives 100 % duty.
- **Dead time**, one instance per leg (`hi` driven from `raw`, `lo` driven from ~`raw`):
  - A rising edge of the leg's input starts a down-counter loaded with `deadtime`.
  - The gate rises only when the counter has expired and the input is still high.
  - A falling edge drops the gate on the next clock and cancels any pending rise.
  - Pulses shorter than `deadtime` are swallowed.
  - `deadtime` is sampled at each rising edge of the leg's input.
- **Invariant**: `pwm_hi` & `pwm_lo` is never 1, including at reset, at enable and disable, and at 0 %/100 % duty.
- At 100 % duty, `pwm_lo` stays 0 for the whole period. At 0 % duty, `pwm_hi` stays 0 for the whole period.

## Timing
- **Reset values**: state=IDLE, cnt=0, `duty_sh`=0, `duty_act`=0, `per_act`=2, dead-time counters=0, `pwm_hi`=0, `pwm_lo`=0, `cyc_start`=0.
- **Gate latency**: a gate transition appears 1 clock after the `raw` change when `deadtime`=0, and `deadtime`+1 clocks after it for rising edges.
- **Duty update latency**: a `duty_vld` accepted at cycle t takes effect at the next cnt=0. This is at most `per_act`+1 cycles later.
- `cyc_start` is registered and coincides with cnt=0.
- **Reset mid-period**: everything returns to the reset values asynchronously. After `rst` deasserts with `en`=1, RUN begins one clock after the first clock edge.
- `period` and `deadtime` may change at any time. Neither has any effect mid-period.

## Structure
- **Package `dc_pwm_pkg`**: `pwm_state_t` enum {IDLE, RUN}, `DUTY_W_DEF`=14, `DT_W_DEF`=6, `PER_MIN`=2.
- **Sub-module `dc_deadtime`**: inputs `clk`, `rst`, `in`, `dt`, `kill`; output `out`. Instantiated twice.
- The top holds the FSM, counter, shadow registers and clamp.
- Expected implementation size is about 200 lines.

## Test plan
- **Basic PWM**: reset, then `period`=9, `deadtime`=0, `duty_vld` with `duty`=4, `en`=1.
  - Expect `cyc_start` every 10 cycles.
  - From the second period: `pwm_hi` high 4 cycles, `pwm_lo` high 6 cycles, never overlapping.
- **Clamp**: `duty`=−5 → `duty_act`=0 and `pwm_hi` constant 0. `duty`=0x1FFF with `period`=9 → `duty_act`=10, `pwm_hi` constant 1 and `pwm_lo` constant 0.
- **Dead time**: `period`=19, `duty`=10, `deadtime`=3.
  - `pwm_hi` high 7 cycles, `pwm_lo` high 7 cycles, 3 both-low cycles at each edge.
  - With `duty`=2, `pwm_hi` never rises.
- **Shadowing**:
  - A `duty_vld` mid-period (cnt=5, `duty`=8) leaves the current period unchanged. Next period `duty_act`=8.
  - A `duty_vld` exactly on the wrap cycle is used immediately.
  - Two strobes in one period → the last value wins.
- **Enable/reset**:
  - Dropping `en` at cnt=3 forces both gates to 0 on the next edge and cnt to 0.
  - Asserting `rst` mid-period asynchronously forces all outputs to 0.
  - Re-enabling produces `cyc_start` on the first RUN cycle.
- **Overlap assertion**: a random `duty`/`period`/`deadtime` sweep with `!(pwm_hi && pwm_lo)` checked every cycle.
